// File: rtl/dma_lite_pkg.sv
// Shared definitions for the DMA AXI4-Lite register-programming path:
// one-hot FSM encoding, AXI response codes and DMA register byte offsets.
package dma_lite_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'b001,
        ADDR_DATA = 3'b010,
        WAIT_B    = 3'b100
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [9:0] REG_DMACR  = 10'h000;
    localparam logic [9:0] REG_DMASR  = 10'h004;
    localparam logic [9:0] REG_SA     = 10'h018;
    localparam logic [9:0] REG_MSB    = 10'h01C;
    localparam logic [9:0] REG_LENGTH = 10'h028;

endpackage

// File: rtl/lite_write_master_if.sv
// AXI4-Lite write-only channel bundle (AW, W, B) between the lite write
// master and the DMA core's register slave port.
interface lite_write_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m_axi_awaddr;
    logic [2:0]          m_axi_awprot;
    logic                m_axi_awvalid;
    logic                m_axi_awready;
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic                m_axi_wvalid;
    logic                m_axi_wready;
    logic [1:0]          m_axi_bresp;
    logic                m_axi_bvalid;
    logic                m_axi_bready;

    modport master (
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_bready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_bready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );

endinterface

// File: rtl/lite_write_master.sv
// AXI4-Lite single-outstanding write master: one-cycle request in, AW/W/B out,
// one-cycle lite_end/lite_err back. Optional watchdog under `LITE_TIMEOUT_EN.
module lite_write_master
    import dma_lite_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lite_valid,
    input  logic [ADDR_W-1:0]       lite_awaddr,
    input  logic [DATA_W-1:0]       lite_wdata,
    output logic                    lite_end,
    output logic                    lite_err,
    output logic                    lite_busy,
    lite_write_master_if.master     m_axi
);

    if (!(DATA_W == 32 || DATA_W == 64) || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("lite_write_master: DATA_W must be 32 or 64 and TIMEOUT_CYCLES >= 1");
    end

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic awvalid_q, wvalid_q, bready_q, aw_done_q, w_done_q, end_q, err_q, busy_q;
    logic awvalid_d, wvalid_d, bready_d, aw_done_d, w_done_d, end_d, err_d, busy_d;
    logic aw_fire, w_fire, b_fire, both_done, timeout;

    assign aw_fire   = awvalid_q & m_axi.m_axi_awready;
    assign w_fire    = wvalid_q & m_axi.m_axi_wready;
    assign b_fire    = bready_q & m_axi.m_axi_bvalid;
    // Covers AW and W completing on the same edge as well as skewed completion.
    assign both_done = (aw_done_q | aw_fire) & (w_done_q | w_fire);

`ifdef LITE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (state == IDLE)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

    assign timeout = (state != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (lite_valid) state_next = ADDR_DATA;
            ADDR_DATA: begin
                if (timeout)
                    state_next = IDLE;
                else if (both_done)
                    state_next = WAIT_B;
            end
            WAIT_B:    if (b_fire || timeout) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        awvalid_d = awvalid_q & ~aw_fire;
        wvalid_d  = wvalid_q & ~w_fire;
        bready_d  = bready_q;
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        end_d     = 1'b0;
        err_d     = 1'b0;
        busy_d    = busy_q;
        case (state)
            IDLE: begin
                if (lite_valid) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ADDR_DATA: begin
                if (timeout) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    end_d     = 1'b1;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                end else if (both_done) begin
                    bready_d  = 1'b1;
                end
            end
            WAIT_B: begin
                // A real response wins over a watchdog expiry on the same edge.
                if (b_fire) begin
                    bready_d = 1'b0;
                    end_d    = 1'b1;
                    err_d    = (m_axi.m_axi_bresp != RESP_OKAY);
                    busy_d   = 1'b0;
                end else if (timeout) begin
                    bready_d = 1'b0;
                    end_d    = 1'b1;
                    err_d    = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            end_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            end_q     <= end_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // Request payload is only sampled when idle, so it stays stable under valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (state == IDLE && lite_valid) begin
            addr_q <= lite_awaddr;
            data_q <= lite_wdata;
        end
    end

    assign lite_end            = end_q;
    assign lite_err            = err_q;
    assign lite_busy           = busy_q;
    assign m_axi.m_axi_awaddr  = addr_q;
    assign m_axi.m_axi_awprot  = 3'b000;
    assign m_axi.m_axi_awvalid = awvalid_q;
    assign m_axi.m_axi_wdata   = data_q;
    assign m_axi.m_axi_wstrb   = '1;
    assign m_axi.m_axi_wvalid  = wvalid_q;
    assign m_axi.m_axi_bready  = bready_q;

endmodule

// File: tb/tb_lite_write_master.sv
// Directed bench for lite_write_master: reset, normal, skewed, error, busy,
// back-to-back, mid-transaction reset and (with LITE_TIMEOUT_EN) watchdog.
module tb_lite_write_master;
    import dma_lite_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              lite_valid;
    logic [ADDR_W-1:0] lite_awaddr;
    logic [DATA_W-1:0] lite_wdata;
    logic              lite_end, lite_err, lite_busy;

    int vectors = 0;
    int miscompares = 0;
    int aw_count = 0;
    int end_count = 0;

    lite_write_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    lite_write_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .lite_valid (lite_valid),
        .lite_awaddr(lite_awaddr),
        .lite_wdata (lite_wdata),
        .lite_end   (lite_end),
        .lite_err   (lite_err),
        .lite_busy  (lite_busy),
        .m_axi      (axi)
    );

    always #5 clk = ~clk;

    // Handshake/pulse counters sampled mid-cycle while signals are stable.
    always @(negedge clk) begin
        if (axi.m_axi_awvalid && axi.m_axi_awready) aw_count++;
        if (lite_end) end_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        lite_valid  = 1'b1;
        lite_awaddr = a;
        lite_wdata  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        lite_valid = 1'b0;
        lite_awaddr = '0;
        lite_wdata = '0;
        axi.m_axi_awready = 1'b0;
        axi.m_axi_wready  = 1'b0;
        axi.m_axi_bvalid  = 1'b0;
        axi.m_axi_bresp   = RESP_OKAY;
        tick();
        tick();
        check("rst_awvalid", axi.m_axi_awvalid, 0);
        check("rst_wvalid",  axi.m_axi_wvalid, 0);
        check("rst_bready",  axi.m_axi_bready, 0);
        check("rst_end",     lite_end, 0);
        check("rst_busy",    lite_busy, 0);
        check("rst_awaddr",  axi.m_axi_awaddr, 0);
        check("rst_wdata",   axi.m_axi_wdata, 0);
        check("rst_wstrb",   axi.m_axi_wstrb, 64'hF);
        check("rst_awprot",  axi.m_axi_awprot, 0);
        rst = 1'b0;
        tick();

        // 1: ready slave, bvalid already high (must not be taken before bready)
        axi.m_axi_awready = 1'b1;
        axi.m_axi_wready  = 1'b1;
        axi.m_axi_bvalid  = 1'b1;
        request(REG_DMACR, 32'h0101_1005);
        tick();
        lite_valid = 1'b0;
        check("t1_awvalid", axi.m_axi_awvalid, 1);
        check("t1_wvalid",  axi.m_axi_wvalid, 1);
        check("t1_busy",    lite_busy, 1);
        check("t1_awaddr",  axi.m_axi_awaddr, 64'h000);
        check("t1_wdata",   axi.m_axi_wdata, 64'h0101_1005);
        check("t1_bready0", axi.m_axi_bready, 0);
        tick();
        check("t1_awdrop",  axi.m_axi_awvalid, 0);
        check("t1_wdrop",   axi.m_axi_wvalid, 0);
        check("t1_bready",  axi.m_axi_bready, 1);
        check("t1_end_early", lite_end, 0);
        tick();
        check("t1_end",     lite_end, 1);
        check("t1_err",     lite_err, 0);
        check("t1_busy_end", lite_busy, 0);
        check("t1_bready_drop", axi.m_axi_bready, 0);
        axi.m_axi_bvalid = 1'b0;
        tick();
        check("t1_end_once", lite_end, 0);

        // 2: W completes 4 cycles ahead of AW, B two cycles after
        axi.m_axi_awready = 1'b0;
        axi.m_axi_wready  = 1'b0;
        request(REG_SA, 32'hCAFE_0018);
        tick();
        lite_valid = 1'b0;
        check("t2_awvalid", axi.m_axi_awvalid, 1);
        check("t2_wvalid",  axi.m_axi_wvalid, 1);
        axi.m_axi_wready = 1'b1;
        tick();
        axi.m_axi_wready = 1'b0;
        check("t2_wdrop",   axi.m_axi_wvalid, 0);
        check("t2_awhold",  axi.m_axi_awvalid, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_awhold_loop", axi.m_axi_awvalid, 1);
            check("t2_addr_stable", axi.m_axi_awaddr, 64'h018);
            check("t2_no_bready",   axi.m_axi_bready, 0);
        end
        axi.m_axi_awready = 1'b1;
        tick();
        axi.m_axi_awready = 1'b0;
        check("t2_awdrop",  axi.m_axi_awvalid, 0);
        check("t2_bready",  axi.m_axi_bready, 1);
        tick();
        check("t2_bready_wait", axi.m_axi_bready, 1);
        check("t2_no_end",  lite_end, 0);
        axi.m_axi_bvalid = 1'b1;
        axi.m_axi_bresp  = RESP_OKAY;
        tick();
        axi.m_axi_bvalid = 1'b0;
        check("t2_end",     lite_end, 1);
        check("t2_err",     lite_err, 0);
        tick();
        check("t2_end_once", lite_end, 0);
        check("t2_idle_busy", lite_busy, 0);

        // 3: SLVERR response
        axi.m_axi_awready = 1'b1;
        axi.m_axi_wready  = 1'b1;
        axi.m_axi_bvalid  = 1'b1;
        axi.m_axi_bresp   = RESP_SLVERR;
        request(REG_LENGTH, 32'h0000_0100);
        tick();
        lite_valid = 1'b0;
        check("t3_awaddr",  axi.m_axi_awaddr, 64'h028);
        tick();
        tick();
        check("t3_end",     lite_end, 1);
        check("t3_err",     lite_err, 1);
        axi.m_axi_bvalid = 1'b0;
        axi.m_axi_bresp  = RESP_OKAY;
        tick();
        check("t3_end_drop", lite_end, 0);
        check("t3_err_drop", lite_err, 0);

        // 4: request while busy is dropped; request in lite_end cycle is taken
        aw_count = 0;
        end_count = 0;
        request(REG_DMASR, 32'h0000_0011);
        tick();
        request(10'h3FF, 32'h0000_0BAD);
        tick();
        lite_valid = 1'b0;
        check("t4_bready",  axi.m_axi_bready, 1);
        check("t4_addr_kept", axi.m_axi_awaddr, 64'h004);
        check("t4_data_kept", axi.m_axi_wdata, 64'h11);
        axi.m_axi_bvalid = 1'b1;
        tick();
        check("t4_end_a",   lite_end, 1);
        request(REG_MSB, 32'h0000_1C1C);
        tick();
        lite_valid = 1'b0;
        check("t4_end_a_once", lite_end, 0);
        check("t4_b2b_awvalid", axi.m_axi_awvalid, 1);
        check("t4_b2b_awaddr",  axi.m_axi_awaddr, 64'h01C);
        check("t4_b2b_busy",    lite_busy, 1);
        tick();
        tick();
        check("t4_end_c",   lite_end, 1);
        axi.m_axi_bvalid = 1'b0;
        tick();
        check("t4_aw_count",  aw_count, 2);
        check("t4_end_count", end_count, 2);

        // 5: reset asserted while waiting for B
        end_count = 0;
        request(REG_DMASR, 32'h0000_0005);
        tick();
        lite_valid = 1'b0;
        tick();
        check("t5_in_wait_b", axi.m_axi_bready, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_awvalid", axi.m_axi_awvalid, 0);
        check("t5_rst_wvalid",  axi.m_axi_wvalid, 0);
        check("t5_rst_bready",  axi.m_axi_bready, 0);
        check("t5_rst_busy",    lite_busy, 0);
        check("t5_rst_end",     lite_end, 0);
        tick();
        rst = 1'b0;
        tick();
        check("t5_no_end", end_count, 0);
        axi.m_axi_bvalid = 1'b1;
        request(REG_DMACR, 32'h0000_0007);
        tick();
        lite_valid = 1'b0;
        check("t5_awaddr", axi.m_axi_awaddr, 64'h000);
        check("t5_wdata",  axi.m_axi_wdata, 64'h7);
        tick();
        tick();
        check("t5_end",  lite_end, 1);
        check("t5_err",  lite_err, 0);
        axi.m_axi_bvalid = 1'b0;
        tick();

`ifdef LITE_TIMEOUT_EN
        // 6: slave never accepts the address; watchdog fires after 16 cycles
        axi.m_axi_awready = 1'b0;
        axi.m_axi_wready  = 1'b1;
        request(REG_SA, 32'h0000_0066);
        tick();
        lite_valid = 1'b0;
        check("t6_awvalid", axi.m_axi_awvalid, 1);
        for (int k = 1; k < 16; k++) begin
            tick();
            check("t6_awhold", axi.m_axi_awvalid, 1);
            check("t6_no_end", lite_end, 0);
        end
        tick();
        check("t6_awdrop", axi.m_axi_awvalid, 0);
        check("t6_end",    lite_end, 1);
        check("t6_err",    lite_err, 1);
        check("t6_busy",   lite_busy, 0);
        tick();
        check("t6_end_once", lite_end, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
